// File: rtl/versat_ctrl_pkg.sv
// Shared definitions for the Versat buffer sequencer: FSM state encoding
// and the width helper used to size the shared phase counter.
package versat_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FILL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_TAIL   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic int cnt_width(input int addr_w, input int len_w);
        return (addr_w > len_w) ? addr_w : len_w;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with a zero flag; it saturates at zero so it never
// wraps, even if the controller keeps the decrement enable high.
module phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/buffer_seq_ctrl.sv
// Sequencer for one Versat Buffer delay unit: flush, fill for 'amount'
// cycles, stream for 'len' cycles, then cover the buffer's output latency.
//
// state  | meaning
// IDLE   | waiting for start; config latched on accept
// CLEAR  | one-cycle FIFO flush
// FILL   | running, priming the delay line (amount cycles)
// STREAM | running, producing delayed samples (len cycles)
// TAIL   | running off; last valid sample leaves the buffer
// DONE   | one-cycle completion pulse
module buffer_seq_ctrl
    import versat_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_amount,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              buf_clear,
    output logic              buf_run,
    output logic              buf_running,
    output logic [ADDR_W-1:0] buf_amount,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int CNT_W = cnt_width(ADDR_W, LEN_W);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_r;
    logic               abort_take;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (abort)                   state_nxt = ST_IDLE;
                else if (len_r == '0)        state_nxt = ST_DONE;
                else if (buf_amount == '0)   state_nxt = ST_STREAM;
                else                         state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (cnt_zero) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (cnt_zero) state_nxt = ST_TAIL;
            end
            ST_TAIL:   state_nxt = abort ? ST_IDLE : ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign abort_take = abort && (state != ST_IDLE) && (state != ST_DONE);

    // One counter serves both running phases; it is reloaded on every phase entry.
    assign cnt_load = ((state == ST_CLEAR) &&
                       ((state_nxt == ST_FILL) || (state_nxt == ST_STREAM))) ||
                      ((state == ST_FILL) && (state_nxt == ST_STREAM));
    assign cnt_val  = (state_nxt == ST_FILL) ? (CNT_W'(buf_amount) - CNT_W'(1))
                                             : (CNT_W'(len_r) - CNT_W'(1));
    assign cnt_dec  = ((state == ST_FILL) || (state == ST_STREAM)) && !cnt_zero;

    phase_counter #(
        .W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_r       <= '0;
            buf_amount  <= '0;
            buf_clear   <= 1'b0;
            buf_run     <= 1'b0;
            buf_running <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && start) begin
                buf_amount <= cfg_amount;
                len_r      <= cfg_len;
            end
            buf_clear   <= (state_nxt == ST_CLEAR);
            buf_run     <= (state == ST_CLEAR) &&
                           ((state_nxt == ST_FILL) || (state_nxt == ST_STREAM));
            buf_running <= (state_nxt == ST_FILL) || (state_nxt == ST_STREAM);
            // Buffer output lags its input by one cycle, hence STREAM delayed.
            out_valid   <= (state == ST_STREAM) && !abort;
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
            aborted     <= abort_take;
        end
    end

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Directed bench for buffer_seq_ctrl: per-vector output windows are recorded
// as cycle bitmasks and compared against hand-computed windows.
module tb_buffer_seq_ctrl;

    localparam int ADDR_W = 6;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] cfg_amount;
    logic [LEN_W-1:0]  cfg_len;
    logic              buf_clear;
    logic              buf_run;
    logic              buf_running;
    logic [ADDR_W-1:0] buf_amount;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              aborted;

    int n_chk;
    int n_fail;

    logic [63:0] m_clear, m_run, m_running, m_valid, m_busy, m_done, m_aborted;

    buffer_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_amount  (cfg_amount),
        .cfg_len     (cfg_len),
        .buf_clear   (buf_clear),
        .buf_run     (buf_run),
        .buf_running (buf_running),
        .buf_amount  (buf_amount),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    amt;
        int    len;
        int    abort_at;
        int    clr;
        int    run;
        int    rlo, rhi;
        int    vlo, vhi;
        int    dn;
        int    ab;
        int    blo, bhi;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [63:0] win(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        if (lo >= 0) begin
            for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Start is driven in cycle 0; outputs are sampled at each negedge.
    task automatic run_vec(input int amt, input int len, input int abort_at, input int ncyc);
        m_clear = '0; m_run = '0; m_running = '0; m_valid = '0;
        m_busy = '0; m_done = '0; m_aborted = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m_clear[c]   = buf_clear;
            m_run[c]     = buf_run;
            m_running[c] = buf_running;
            m_valid[c]   = out_valid;
            m_busy[c]    = busy;
            m_done[c]    = done;
            m_aborted[c] = aborted;
            start = (c == 0);
            abort = (c == abort_at);
            if (c == 0) begin
                cfg_amount = ADDR_W'(amt);
                cfg_len    = LEN_W'(len);
            end else begin
                cfg_amount = 6'h15;
                cfg_len    = 16'h00AB;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int done_cyc;
        int n_valid;
        int n_busy;
        int n_running;

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_amount = '0;
        cfg_len = '0;

        //           name        amt len abort clr run rlo rhi vlo vhi dn  ab  blo bhi
        vecs[0] = '{"a3_l5",      3,  5, -1,   1,  2,  2,  9,  6, 10, 11, -1,  1, 11};
        vecs[1] = '{"a0_l4",      0,  4, -1,   1,  2,  2,  5,  3,  6,  7, -1,  1,  7};
        vecs[2] = '{"a5_l0",      5,  0, -1,   1, -1, -1, -1, -1, -1,  2, -1,  1,  2};
        vecs[3] = '{"abort_strm", 3,  5,  7,   1,  2,  2,  7,  6,  7, -1,  8,  1,  7};
        vecs[4] = '{"a1_l1",      1,  1, -1,   1,  2,  2,  3,  4,  4,  5, -1,  1,  5};
        vecs[5] = '{"abort_clr",  2,  3,  1,   1, -1, -1, -1, -1, -1, -1,  2,  1,  1};
        vecs[6] = '{"abort_done", 0,  1,  4,   1,  2,  2,  2,  3,  3,  4, -1,  1,  4};
        vecs[7] = '{"abort_tail", 0,  2,  4,   1,  2,  2,  3,  3,  4, -1,  5,  1,  4};
        vecs[8] = '{"start_abrt", 2,  2,  0,   1,  2,  2,  5,  5,  6,  7, -1,  1,  7};

        #2;
        chk("reset_outputs",
            {buf_clear, buf_run, buf_running, out_valid, busy, done, aborted, buf_amount},
            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset",
            {buf_clear, buf_run, buf_running, out_valid, busy, done, aborted, buf_amount},
            64'd0);

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v].amt, vecs[v].len, vecs[v].abort_at, 24);
            chk({vecs[v].name, ".clear"},   m_clear,   win(vecs[v].clr, vecs[v].clr));
            chk({vecs[v].name, ".run"},     m_run,     win(vecs[v].run, vecs[v].run));
            chk({vecs[v].name, ".running"}, m_running, win(vecs[v].rlo, vecs[v].rhi));
            chk({vecs[v].name, ".valid"},   m_valid,   win(vecs[v].vlo, vecs[v].vhi));
            chk({vecs[v].name, ".busy"},    m_busy,    win(vecs[v].blo, vecs[v].bhi));
            chk({vecs[v].name, ".done"},    m_done,    win(vecs[v].dn, vecs[v].dn));
            chk({vecs[v].name, ".aborted"}, m_aborted, win(vecs[v].ab, vecs[v].ab));
            chk({vecs[v].name, ".amount"},  64'(buf_amount), 64'(vecs[v].amt));
        end

        // Restart attempts while busy, then asynchronous reset mid-run.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) begin
                chk("restart.running_c5", 64'(buf_running), 64'd1);
                chk("restart.amount_c5", 64'(buf_amount), 64'd3);
            end
            if (c == 7) begin
                chk("restart.amount_c7", 64'(buf_amount), 64'd3);
                chk("restart.valid_c7", 64'(out_valid), 64'd1);
            end
            start = (c == 0) || (c == 4) || (c == 6);
            cfg_amount = (c == 0) ? 6'd3 : 6'd7;
            cfg_len    = (c == 0) ? 16'd5 : 16'd9;
        end
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async",
            {buf_clear, buf_run, buf_running, out_valid, busy, done, aborted, buf_amount},
            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(1, 2, -1, 16);
        chk("post_reset.running", m_running, win(2, 4));
        chk("post_reset.valid",   m_valid,   win(4, 5));
        chk("post_reset.done",    m_done,    win(6, 6));
        chk("post_reset.busy",    m_busy,    win(1, 6));

        // Maximum amount and length.
        done_cyc = -1;
        n_valid = 0;
        n_busy = 0;
        n_running = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (out_valid)   n_valid++;
            if (busy)        n_busy++;
            if (buf_running) n_running++;
            if (done && (done_cyc < 0)) done_cyc = c;
            start = (c == 0);
            cfg_amount = 6'd63;
            cfg_len = 16'hFFFF;
            if ((done_cyc >= 0) && (c > done_cyc + 2)) break;
        end
        start = 1'b0;
        if (done_cyc < 0) $display("FAIL max.timeout: got no done expected done within 70000 cycles");
        chk("max.done_cycle", 64'(done_cyc), 64'd65601);
        chk("max.valid_count", 64'(n_valid), 64'd65535);
        chk("max.busy_count", 64'(n_busy), 64'd65601);
        chk("max.running_count", 64'(n_running), 64'd65598);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
